// File: rtl/uart_pkg.sv
// Shared types for the UART link: parity modes and the TX/RX state encodings.
// Also holds the parity helper used by both directions.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_EVEN,
      PAR_ODD
   } parity_t;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } txState_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rxState_t;

   // xorAll is the XOR of the payload; odd mode inverts it
   function automatic logic parityOf(parity_t mode, logic xorAll);
      return (mode == PAR_ODD) ? ~xorAll : xorAll;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: two-flop synchroniser, falling-edge start detect, mid-bit sampling.
// Ports: clk, reset, rx in; dataOut, rxValid, parityErr, frameErr out.
module uart_rx
   import uart_pkg::*;
#(
   parameter int      DATA_W       = 8,
   parameter int      CLKS_PER_BIT = 10416,
   parameter parity_t PARITY       = PAR_NONE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   output logic [DATA_W-1:0] dataOut,
   output logic              rxValid,
   output logic              parityErr,
   output logic              frameErr
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   rxState_t          state;
   logic              sync1;
   logic              sync2;
   logic              rxPrev;
   logic [CNT_W-1:0]  cnt;
   logic [BIT_W-1:0]  bitIdx;
   logic [DATA_W-1:0] shReg;
   logic [DATA_W-1:0] shNext;
   logic              parBad;
   logic              fallEdge;
   logic              cntLast;

   // Only a high-to-low transition arms the receiver, so a line held low
   // after a framing error cannot start a new frame until it rises again.
   assign fallEdge = rxPrev & ~sync2;
   assign cntLast  = (cnt == CNT_LAST);

   always_comb begin
      shNext = DATA_W'({sync2, shReg} >> 1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         rxPrev    <= 1'b1;
         state     <= RX_IDLE;
         cnt       <= '0;
         bitIdx    <= '0;
         shReg     <= '0;
         parBad    <= 1'b0;
         dataOut   <= '0;
         rxValid   <= 1'b0;
         parityErr <= 1'b0;
         frameErr  <= 1'b0;
      end else begin
         sync1     <= rx;
         sync2     <= sync1;
         rxPrev    <= sync2;
         rxValid   <= 1'b0;
         parityErr <= 1'b0;
         frameErr  <= 1'b0;
         case (state)
            RX_IDLE: begin
               cnt <= '0;
               if (fallEdge) begin
                  state <= RX_START;
               end
            end
            RX_START: begin
               if (cnt == HALF_LAST) begin
                  cnt    <= '0;
                  bitIdx <= '0;
                  parBad <= 1'b0;
                  // still high at mid-start: treat as a glitch
                  state  <= sync2 ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_DATA: begin
               cnt <= cntLast ? '0 : cnt + 1'b1;
               if (cntLast) begin
                  shReg  <= shNext;
                  bitIdx <= bitIdx + 1'b1;
                  if (bitIdx == BIT_LAST) begin
                     state <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                  end
               end
            end
            RX_PARITY: begin
               cnt <= cntLast ? '0 : cnt + 1'b1;
               if (cntLast) begin
                  parBad <= sync2 ^ parityOf(PARITY, ^shReg);
                  state  <= RX_STOP;
               end
            end
            RX_STOP: begin
               cnt <= cntLast ? '0 : cnt + 1'b1;
               if (cntLast) begin
                  dataOut   <= shReg;
                  rxValid   <= 1'b1;
                  parityErr <= (PARITY != PAR_NONE) & parBad;
                  frameErr  <= ~sync2;
                  state     <= RX_IDLE;
               end
            end
            default: begin
               state <= RX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_link.sv
// UART link: edge-triggered transmitter plus an independent uart_rx receiver.
// Ports: clk, reset, sendBtn, dataIn, rx in; tx, dataOut, rxValid, parityErr, frameErr, txBusy out.
module uart_link
   import uart_pkg::*;
#(
   parameter int      DATA_W       = 8,
   parameter int      CLKS_PER_BIT = 10416,
   parameter parity_t PARITY       = PAR_NONE,
   parameter int      STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sendBtn,
   input  logic [DATA_W-1:0] dataIn,
   output logic              tx,
   input  logic              rx,
   output logic [DATA_W-1:0] dataOut,
   output logic              rxValid,
   output logic              parityErr,
   output logic              frameErr,
   output logic              txBusy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [1:0] STOP_LAST = 2'(STOP_BITS);

   txState_t          txState;
   logic [CNT_W-1:0]  txCnt;
   logic [BIT_W-1:0]  txBit;
   logic [1:0]        txStop;
   logic [DATA_W-1:0] txSh;
   logic [DATA_W-1:0] txShNext;
   logic              txPar;
   logic              btnPrev;
   logic              btnRise;
   logic              txLast;

   // btnPrev resets high so a button already held at release does not send
   assign btnRise  = sendBtn & ~btnPrev;
   assign txLast   = (txCnt == CNT_LAST);
   assign txShNext = txSh >> 1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btnPrev <= 1'b1;
         txState <= TX_IDLE;
         txCnt   <= '0;
         txBit   <= '0;
         txStop  <= '0;
         txSh    <= '0;
         txPar   <= 1'b0;
         tx      <= 1'b1;
         txBusy  <= 1'b0;
      end else begin
         btnPrev <= sendBtn;
         if (txState == TX_IDLE) begin
            txCnt <= '0;
            if (btnRise) begin
               txSh    <= dataIn;
               txPar   <= parityOf(PARITY, ^dataIn);
               tx      <= 1'b0;
               txBusy  <= 1'b1;
               txState <= TX_START;
            end
         end else begin
            txCnt <= txLast ? '0 : txCnt + 1'b1;
            if (txLast) begin
               case (txState)
                  TX_START: begin
                     tx      <= txSh[0];
                     txBit   <= '0;
                     txState <= TX_DATA;
                  end
                  TX_DATA: begin
                     txSh  <= txShNext;
                     txBit <= txBit + 1'b1;
                     if (txBit != BIT_LAST) begin
                        tx <= txShNext[0];
                     end else if (PARITY != PAR_NONE) begin
                        tx      <= txPar;
                        txState <= TX_PARITY;
                     end else begin
                        tx      <= 1'b1;
                        txStop  <= 2'd1;
                        txState <= TX_STOP;
                     end
                  end
                  TX_PARITY: begin
                     tx      <= 1'b1;
                     txStop  <= 2'd1;
                     txState <= TX_STOP;
                  end
                  TX_STOP: begin
                     if (txStop == STOP_LAST) begin
                        txBusy  <= 1'b0;
                        txState <= TX_IDLE;
                     end else begin
                        txStop <= txStop + 1'b1;
                     end
                  end
                  default: begin
                     tx      <= 1'b1;
                     txBusy  <= 1'b0;
                     txState <= TX_IDLE;
                  end
               endcase
            end
         end
      end
   end

   uart_rx #(
      .DATA_W      (DATA_W),
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .PARITY      (PARITY)
   ) rxInst (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .dataOut  (dataOut),
      .rxValid  (rxValid),
      .parityErr(parityErr),
      .frameErr (frameErr)
   );

endmodule

// File: tb/tb_uart_link.sv
// Directed bench for uart_link: 4-bit even parity, 4 clocks per bit.
// tx is looped to rx except when the bench drives rx directly.
module tb_uart_link;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       sendBtn;
   logic [3:0] dataIn;
   logic       tx;
   logic       rx;
   logic [3:0] dataOut;
   logic       rxValid;
   logic       parityErr;
   logic       frameErr;
   logic       txBusy;

   logic       loop;
   logic       rxDrv;

   int         nAsserts = 0;
   int         nFails = 0;

   int         vCnt = 0;
   logic [3:0] lastData = '0;
   logic       lastPe = 1'b0;
   logic       lastFe = 1'b0;

   assign rx = loop ? tx : rxDrv;

   always #5 clk = ~clk;

   uart_link #(
      .DATA_W      (4),
      .CLKS_PER_BIT(4),
      .PARITY      (PAR_EVEN),
      .STOP_BITS   (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .sendBtn  (sendBtn),
      .dataIn   (dataIn),
      .tx       (tx),
      .rx       (rx),
      .dataOut  (dataOut),
      .rxValid  (rxValid),
      .parityErr(parityErr),
      .frameErr (frameErr),
      .txBusy   (txBusy)
   );

   always @(negedge clk) begin
      if (rxValid === 1'b1) begin
         vCnt     = vCnt + 1;
         lastData = dataOut;
         lastPe   = parityErr;
         lastFe   = frameErr;
      end
   end

   // bits[0] goes out first, each held 4 cycles
   task automatic sendRx(input logic [6:0] bits);
      for (int i = 0; i < 7; i++) begin
         rxDrv = bits[i];
         repeat (4) @(negedge clk);
      end
      rxDrv = 1'b1;
   endtask

   task automatic test_reset;
      reset   = 1'b1;
      sendBtn = 1'b0;
      dataIn  = '0;
      loop    = 1'b1;
      rxDrv   = 1'b1;
      repeat (3) @(negedge clk);
      nAsserts++;
      if ({tx, txBusy, rxValid, parityErr, frameErr, dataOut} !== 9'b100000000) begin
         nFails++;
         $display("FAIL reset_state: got tx/busy/v/pe/fe/data=%b required 100000000",
                  {tx, txBusy, rxValid, parityErr, frameErr, dataOut});
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      nAsserts++;
      if ({tx, txBusy} !== 2'b10) begin
         nFails++;
         $display("FAIL idle_after_reset: got tx/busy=%b required 10", {tx, txBusy});
      end
   endtask

   task automatic test_frame;
      logic [6:0] expBits;
      int         v0;
      expBits = 7'b1111010;
      v0      = vCnt;
      loop    = 1'b1;
      dataIn  = 4'd13;
      sendBtn = 1'b1;
      for (int k = 0; k < 28; k++) begin
         @(negedge clk);
         nAsserts++;
         if ({tx, txBusy} !== {expBits[k / 4], 1'b1}) begin
            nFails++;
            $display("FAIL tx_bit cycle %0d: got tx/busy=%b%b required %b1",
                     k, tx, txBusy, expBits[k / 4]);
         end
         if (rxValid === 1'b0) begin
            nAsserts++;
            if ({parityErr, frameErr} !== 2'b00) begin
               nFails++;
               $display("FAIL err_idle: got pe/fe=%b%b required 00", parityErr, frameErr);
            end
         end
      end
      @(negedge clk);
      nAsserts++;
      if ({tx, txBusy} !== 2'b10) begin
         nFails++;
         $display("FAIL busy_fall: got tx/busy=%b%b required 10", tx, txBusy);
      end
      sendBtn = 1'b0;
      repeat (12) @(negedge clk);
      nAsserts++;
      if ({vCnt - v0, lastData, lastPe, lastFe} !== {32'd1, 4'd13, 2'b00}) begin
         nFails++;
         $display("FAIL loop_rx: got count=%0d data=%0d pe=%b fe=%b required 1 13 0 0",
                  vCnt - v0, lastData, lastPe, lastFe);
      end
   endtask

   task automatic test_hold;
      int  v0;
      int  rises;
      logic prevBusy;
      v0       = vCnt;
      rises    = 0;
      prevBusy = txBusy;
      loop     = 1'b1;
      dataIn   = 4'd6;
      sendBtn  = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (txBusy && !prevBusy) rises++;
         prevBusy = txBusy;
      end
      sendBtn = 1'b0;
      repeat (40) @(negedge clk);
      nAsserts++;
      if (rises !== 1) begin
         nFails++;
         $display("FAIL hold_frames: got %0d frames required 1", rises);
      end
      nAsserts++;
      if ({vCnt - v0, lastData} !== {32'd1, 4'd6}) begin
         nFails++;
         $display("FAIL hold_rx: got count=%0d data=%0d required 1 6", vCnt - v0, lastData);
      end
   endtask

   task automatic test_parity_err;
      int v0;
      v0   = vCnt;
      loop = 1'b0;
      repeat (4) @(negedge clk);
      sendRx(7'b1101010);
      repeat (8) @(negedge clk);
      nAsserts++;
      if ({vCnt - v0, lastData, lastPe, lastFe} !== {32'd1, 4'd5, 2'b10}) begin
         nFails++;
         $display("FAIL parity_err: got count=%0d data=%0d pe=%b fe=%b required 1 5 1 0",
                  vCnt - v0, lastData, lastPe, lastFe);
      end
   endtask

   task automatic test_frame_err;
      int v0;
      v0   = vCnt;
      loop = 1'b0;
      sendRx(7'b0000110);
      rxDrv = 1'b0;
      repeat (8) @(negedge clk);
      nAsserts++;
      if ({vCnt - v0, lastData, lastPe, lastFe} !== {32'd1, 4'd3, 2'b01}) begin
         nFails++;
         $display("FAIL frame_err: got count=%0d data=%0d pe=%b fe=%b required 1 3 0 1",
                  vCnt - v0, lastData, lastPe, lastFe);
      end
      repeat (60) @(negedge clk);
      rxDrv = 1'b1;
      repeat (12) @(negedge clk);
      nAsserts++;
      if (vCnt - v0 !== 1) begin
         nFails++;
         $display("FAIL break_hold: got count=%0d required 1", vCnt - v0);
      end
      sendRx(7'b1010010);
      repeat (8) @(negedge clk);
      nAsserts++;
      if ({vCnt - v0, lastData, lastPe, lastFe} !== {32'd2, 4'd9, 2'b00}) begin
         nFails++;
         $display("FAIL rearm: got count=%0d data=%0d pe=%b fe=%b required 2 9 0 0",
                  vCnt - v0, lastData, lastPe, lastFe);
      end
   endtask

   task automatic test_glitch;
      int v0;
      v0    = vCnt;
      loop  = 1'b0;
      rxDrv = 1'b0;
      @(negedge clk);
      rxDrv = 1'b1;
      repeat (20) @(negedge clk);
      nAsserts++;
      if (vCnt - v0 !== 0) begin
         nFails++;
         $display("FAIL glitch: got count=%0d required 0", vCnt - v0);
      end
      sendRx(7'b1010100);
      repeat (8) @(negedge clk);
      nAsserts++;
      if ({vCnt - v0, lastData, lastPe, lastFe} !== {32'd1, 4'd10, 2'b00}) begin
         nFails++;
         $display("FAIL after_glitch: got count=%0d data=%0d pe=%b fe=%b required 1 10 0 0",
                  vCnt - v0, lastData, lastPe, lastFe);
      end
   endtask

   task automatic test_reset_mid;
      int  v0;
      int  busySeen;
      loop    = 1'b1;
      rxDrv   = 1'b1;
      sendBtn = 1'b0;
      repeat (4) @(negedge clk);
      v0      = vCnt;
      dataIn  = 4'd12;
      sendBtn = 1'b1;
      repeat (9) @(negedge clk);
      nAsserts++;
      if (txBusy !== 1'b1) begin
         nFails++;
         $display("FAIL busy_pre_reset: got %b required 1", txBusy);
      end
      reset = 1'b1;
      #1;
      nAsserts++;
      if ({tx, txBusy} !== 2'b10) begin
         nFails++;
         $display("FAIL async_reset: got tx/busy=%b%b required 10", tx, txBusy);
      end
      repeat (3) @(negedge clk);
      reset    = 1'b0;
      busySeen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (txBusy !== 1'b0) busySeen++;
      end
      nAsserts++;
      if (busySeen !== 0) begin
         nFails++;
         $display("FAIL held_btn_send: got %0d busy cycles required 0", busySeen);
      end
      nAsserts++;
      if (vCnt - v0 !== 0) begin
         nFails++;
         $display("FAIL aborted_rx: got count=%0d required 0", vCnt - v0);
      end
      sendBtn = 1'b0;
      @(negedge clk);
      dataIn  = 4'd7;
      sendBtn = 1'b1;
      repeat (45) @(negedge clk);
      sendBtn = 1'b0;
      nAsserts++;
      if ({vCnt - v0, lastData, lastPe, lastFe} !== {32'd1, 4'd7, 2'b00}) begin
         nFails++;
         $display("FAIL send_after_reset: got count=%0d data=%0d pe=%b fe=%b required 1 7 0 0",
                  vCnt - v0, lastData, lastPe, lastFe);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_hold();
      test_parity_err();
      test_frame_err();
      test_glitch();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

// File: doc/uart_link.md
UART_LINK -- requirements
Module: uart_link

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame (1..16).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 10416, clk cycles per serial bit (100 MHz / 9600 baud, legal minimum 4).
REQ-003 SHALL have parameter PARITY, default PAR_NONE, parity mode: PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits transmitted (1 or 2).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port sendBtn  input  1  level request to send, e.g. a held button.
REQ-008 SHALL have port dataIn  input  DATA_W  payload to transmit.
REQ-009 SHALL have port tx  output  1  serial line out, idle high.
REQ-010 SHALL have port rx  input  1  asynchronous serial line in, idle high.
REQ-011 SHALL have port dataOut  output  DATA_W  last payload received.
REQ-012 SHALL have port rxValid  output  1  one-cycle pulse, new dataOut.
REQ-013 SHALL have port parityErr  output  1  with rxValid, received parity mismatch.
REQ-014 SHALL have port frameErr  output  1  with rxValid, first stop bit sampled low.
REQ-015 SHALL have port txBusy  output  1  transmitter not idle.

Function
REQ-016 SHALL frame each transmission as start(0), DATA_W bits LSB first, parity bit (omitted for PAR_NONE), then STOP_BITS stop bits(1), each bit held exactly CLKS_PER_BIT cycles.
REQ-017 SHALL set the even-parity bit to XOR of the payload and the odd-parity bit to its inverse.
REQ-018 SHALL start a frame only on a rising edge of sendBtn (registered previous value) while TX is IDLE, latching dataIn that cycle; holding sendBtn SHALL NOT resend, and edges during txBusy SHALL be ignored.
REQ-019 SHALL drive tx low (start) and txBusy high on the cycle after the accepted edge; txBusy SHALL fall on the cycle after the last stop bit ends.
REQ-020 SHALL use TX states IDLE, START, DATA, PARITY, STOP; STOP with a remaining count of STOP_BITS returns to IDLE, and PARITY is skipped when PARITY==PAR_NONE.
REQ-021 SHALL pass rx through a two-flop synchroniser before any use.
REQ-022 SHALL use RX states IDLE, START, DATA, PARITY, STOP; IDLE to START on a synchronised falling edge.
REQ-023 SHALL resample in START after CLKS_PER_BIT/2 cycles; if high (glitch) return to IDLE with no rxValid, else sample each later bit every CLKS_PER_BIT cycles (mid-bit).
REQ-024 SHALL check only the first stop bit on receive; after sampling it, load dataOut, pulse rxValid for one cycle, set parityErr/frameErr valid that cycle, and return to IDLE.
REQ-025 SHALL hold parityErr and frameErr low whenever rxValid is low; parityErr SHALL always be 0 for PAR_NONE.
REQ-026 SHALL deliver a frame even when frameErr=1, and SHALL rearm only after rx is seen high (no false start on a held-low break).
REQ-027 SHALL run TX and RX independently; tx externally looped to rx SHALL round-trip correctly.
REQ-028 SHALL wrap every bit-period counter at CLKS_PER_BIT-1 using $clog2(CLKS_PER_BIT) bits.

Reset
REQ-029 SHALL, while reset is high, asynchronously force tx=1, txBusy=0, dataOut=0, rxValid=0, parityErr=0, frameErr=0, both FSMs to IDLE, all counters to 0, synchroniser flops to 1, and the sendBtn edge register to 1.
REQ-030 SHALL abort any frame in progress on reset mid-frame, with no rxValid for it; a sendBtn already high at reset release SHALL NOT send.

Structure
REQ-031 SHALL place the parity-mode enum (PAR_NONE/PAR_EVEN/PAR_ODD) and the TX/RX state enums in a shared package, uart_pkg.
REQ-032 SHALL implement the receiver as one sub-module, uart_rx, with the transmitter in uart_link.

Verification (DATA_W=4, CLKS_PER_BIT=4, PAR_EVEN, STOP_BITS=1, tx looped to rx)
REQ-033 Bench SHALL check: sendBtn rises with dataIn=13 -> tx emits 0,1,0,1,1,1,1 (start, 1101 LSB first, parity 1, stop), each bit 4 cycles; txBusy high for 28 cycles; rxValid pulses once with dataOut=13, both errors 0.
REQ-034 Bench SHALL check: sendBtn held high 2000 cycles -> exactly one frame, one rxValid.
REQ-035 Bench SHALL check: rx driven directly with dataOut=5 frame carrying parity 1 -> rxValid with dataOut=5, parityErr=1.
REQ-036 Bench SHALL check: rx frame with stop bit 0 -> rxValid with frameErr=1; rx held low afterward -> no further rxValid until rx returns high.
REQ-037 Bench SHALL check: rx low pulse of 1 cycle -> no rxValid, RX back in IDLE.
REQ-038 Bench SHALL check: reset asserted in TX DATA state -> tx=1, txBusy=0 immediately; no rxValid; the next sendBtn rising edge sends normally.
